// File: rtl/frame_buffer_scanout_pkg.sv
// Shared types and default 640x480 timing for the display-side frame store reader.
package frame_buffer_scanout_pkg;

    localparam int unsigned DefHActive     = 640;
    localparam int unsigned DefHFp         = 16;
    localparam int unsigned DefHSync       = 96;
    localparam int unsigned DefHBp         = 48;
    localparam int unsigned DefVActive     = 480;
    localparam int unsigned DefVFp         = 10;
    localparam int unsigned DefVSync       = 2;
    localparam int unsigned DefVBp         = 33;
    localparam int unsigned DefPixelW      = 8;
    localparam int unsigned DefReadLatency = 2;

    // Control bits that must stay aligned with the pixel returned by the frame store.
    typedef struct packed {
        logic frame_start;
        logic vsync;
        logic hsync;
        logic de;
    } scan_ctrl_t;

    function automatic int unsigned cnt_width(input int unsigned total);
        return (total <= 2) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/pipeline_delay.sv
// Fixed-depth shift register with synchronous clear, used to align control with read data.
module pipeline_delay #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             i_clk,
    input  logic             i_srst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = i_data;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign o_data = stage_q[DEPTH-1];

endmodule

// File: rtl/frame_buffer_scanout.sv
// Video timing generator and frame store reader; shows the buffer the rasterizer is not writing
// and latches that choice only at the frame boundary.
module frame_buffer_scanout
    import frame_buffer_scanout_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = DefHActive,
    parameter int unsigned H_FP         = DefHFp,
    parameter int unsigned H_SYNC       = DefHSync,
    parameter int unsigned H_BP         = DefHBp,
    parameter int unsigned V_ACTIVE     = DefVActive,
    parameter int unsigned V_FP         = DefVFp,
    parameter int unsigned V_SYNC       = DefVSync,
    parameter int unsigned V_BP         = DefVBp,
    parameter bit          HSYNC_POL    = 1'b0,
    parameter bit          VSYNC_POL    = 1'b0,
    parameter int unsigned PIXEL_W      = DefPixelW,
    parameter int unsigned READ_LATENCY = DefReadLatency,
    localparam int unsigned ADDR_W      = $clog2(H_ACTIVE * V_ACTIVE)
) (
    input  logic               i_clk,
    input  logic               i_srst,
    input  logic               i_rasterization_target,
    output logic               o_frame_buffer_swap_allowed,
    output logic               o_rd_en,
    output logic               o_rd_buf_sel,
    output logic [ADDR_W-1:0]  o_rd_addr,
    input  logic [PIXEL_W-1:0] i_rd_data,
    output logic [PIXEL_W-1:0] o_pixel,
    output logic               o_de,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = cnt_width(H_TOTAL);
    localparam int unsigned VW      = cnt_width(V_TOTAL);

    // One spare bit so a boundary equal to the total still fits when comparing.
    typedef logic [HW:0] hcmp_t;
    typedef logic [VW:0] vcmp_t;

    localparam hcmp_t H_ACT_B      = hcmp_t'(H_ACTIVE);
    localparam hcmp_t H_SYNC_START = hcmp_t'(H_ACTIVE + H_FP);
    localparam hcmp_t H_SYNC_END   = hcmp_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam hcmp_t H_LAST       = hcmp_t'(H_TOTAL - 1);
    localparam vcmp_t V_ACT_B      = vcmp_t'(V_ACTIVE);
    localparam vcmp_t V_SYNC_START = vcmp_t'(V_ACTIVE + V_FP);
    localparam vcmp_t V_SYNC_END   = vcmp_t'(V_ACTIVE + V_FP + V_SYNC);
    localparam vcmp_t V_LAST       = vcmp_t'(V_TOTAL - 1);

    if (READ_LATENCY < 1) begin : gen_bad_latency
        $error("frame_buffer_scanout: READ_LATENCY must be at least 1");
    end
    // The swap window needs at least one blank line before the settling line.
    if (V_FP + V_SYNC + V_BP < 2) begin : gen_bad_vblank
        $error("frame_buffer_scanout: vertical blanking must span at least 2 lines");
    end

    logic [HW-1:0]     h_q, h_d;
    logic [VW-1:0]     v_q, v_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              buf_sel_q, buf_sel_d;
    logic              allowed_q, allowed_d;
    scan_ctrl_t        ctrl_q, ctrl_d;
    scan_ctrl_t        ctrl_dly;

    hcmp_t h_ext;
    vcmp_t v_ext;
    logic  h_last;
    logic  v_last;
    logic  frame_last;

    always_comb begin
        h_ext      = {1'b0, h_q};
        v_ext      = {1'b0, v_q};
        h_last     = (h_ext == H_LAST);
        v_last     = (v_ext == V_LAST);
        frame_last = h_last && v_last;

        h_d = h_last ? '0 : h_q + HW'(1);
        v_d = v_q;
        if (h_last) begin
            v_d = v_last ? '0 : v_q + VW'(1);
        end

        // Linear address by increment only; ctrl_q.de is the registered read strobe.
        addr_d = addr_q;
        if (frame_last) begin
            addr_d = '0;
        end else if (ctrl_q.de) begin
            addr_d = addr_q + ADDR_W'(1);
        end

        // Display buffer only moves on the last cycle of the frame, so no visible frame tears.
        buf_sel_d = frame_last ? ~i_rasterization_target : buf_sel_q;

        // The last blank line stays closed so the controller settles before the latch.
        allowed_d = (v_ext >= V_ACT_B) && (v_ext < V_LAST);

        ctrl_d.de          = (h_ext < H_ACT_B) && (v_ext < V_ACT_B);
        ctrl_d.hsync       = (h_ext >= H_SYNC_START) && (h_ext < H_SYNC_END);
        ctrl_d.vsync       = (v_ext >= V_SYNC_START) && (v_ext < V_SYNC_END);
        ctrl_d.frame_start = (h_q == '0) && (v_q == '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            h_q       <= '0;
            v_q       <= '0;
            addr_q    <= '0;
            buf_sel_q <= 1'b1;
            allowed_q <= 1'b0;
            ctrl_q    <= '0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            addr_q    <= addr_d;
            buf_sel_q <= buf_sel_d;
            allowed_q <= allowed_d;
            ctrl_q    <= ctrl_d;
        end
    end

    pipeline_delay #(
        .WIDTH ($bits(scan_ctrl_t)),
        .DEPTH (READ_LATENCY)
    ) u_align (
        .i_clk  (i_clk),
        .i_srst (i_srst),
        .i_data (ctrl_q),
        .o_data (ctrl_dly)
    );

    assign o_rd_en                     = ctrl_q.de;
    assign o_rd_addr                   = addr_q;
    assign o_rd_buf_sel                = buf_sel_q;
    assign o_frame_buffer_swap_allowed = allowed_q;

    // Syncs are carried active-high internally so a cleared pipeline reads as inactive.
    assign o_de          = ctrl_dly.de;
    assign o_pixel       = ctrl_dly.de ? i_rd_data : '0;
    assign o_hsync       = HSYNC_POL ? ctrl_dly.hsync : ~ctrl_dly.hsync;
    assign o_vsync       = VSYNC_POL ? ctrl_dly.vsync : ~ctrl_dly.vsync;
    assign o_frame_start = ctrl_dly.frame_start;

endmodule

// File: tb/tb_frame_buffer_scanout.sv
// Directed bench for frame_buffer_scanout on a 7x6 raster (4x3 visible), read latency 2.
module tb_frame_buffer_scanout;

    localparam int FRAME = 42;

    logic       clk = 1'b0;
    logic       srst;
    logic       target;
    logic       allowed;
    logic       rd_en;
    logic       rd_buf_sel;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] pixel;
    logic       de;
    logic       hsync;
    logic       vsync;
    logic       frame_start;

    int total = 0;
    int bad   = 0;
    int n     = 0;
    logic rd_hist [512];

    always #5 clk = ~clk;

    frame_buffer_scanout #(
        .H_ACTIVE     (4),
        .H_FP         (1),
        .H_SYNC       (1),
        .H_BP         (1),
        .V_ACTIVE     (3),
        .V_FP         (1),
        .V_SYNC       (1),
        .V_BP         (1),
        .HSYNC_POL    (1'b0),
        .VSYNC_POL    (1'b0),
        .PIXEL_W      (8),
        .READ_LATENCY (2)
    ) dut (
        .i_clk                       (clk),
        .i_srst                      (srst),
        .i_rasterization_target      (target),
        .o_frame_buffer_swap_allowed (allowed),
        .o_rd_en                     (rd_en),
        .o_rd_buf_sel                (rd_buf_sel),
        .o_rd_addr                   (rd_addr),
        .i_rd_data                   (rd_data),
        .o_pixel                     (pixel),
        .o_de                        (de),
        .o_hsync                     (hsync),
        .o_vsync                     (vsync),
        .o_frame_start               (frame_start)
    );

    // Frame store model: returns {buf_sel, addr} two cycles after the read strobe.
    logic [7:0] mem_q [2];
    always @(posedge clk) begin
        mem_q[0] <= {3'b000, rd_buf_sel, rd_addr};
        mem_q[1] <= mem_q[0];
    end
    assign rd_data = mem_q[1];

    function automatic int hpos(input int p);
        return p % 7;
    endfunction

    function automatic int vpos(input int p);
        return (p / 7) % 6;
    endfunction

    function automatic logic is_active(input int p);
        return (p >= 0) && (hpos(p) < 4) && (vpos(p) < 3);
    endfunction

    function automatic int pix_idx(input int p);
        return vpos(p) * 4 + hpos(p);
    endfunction

    // After tick, outputs reflect the n-th rising edge since reset release.
    task automatic tick();
        @(negedge clk);
        n = n + 1;
        rd_hist[n] = rd_en;
    endtask

    // {rd_en, addr, buf_sel, allowed, de, pixel, frame_start, hsync, vsync}
    localparam logic [18:0] RST_VEC = {1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};

    task automatic test_reset();
        srst   = 1'b1;
        target = 1'b0;
        repeat (10) @(negedge clk);
        total++;
        if ({rd_en, rd_addr, rd_buf_sel, allowed, de, pixel, frame_start, hsync, vsync}
            !== RST_VEC) begin
            bad++;
            $display("FAIL reset_hold got=%b exp=%b",
                     {rd_en, rd_addr, rd_buf_sel, allowed, de, pixel, frame_start, hsync, vsync},
                     RST_VEC);
        end
        srst = 1'b0;
        n    = 0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            total++;
            if (rd_en !== (k <= 4)) begin
                bad++;
                $display("FAIL first_rd_en n=%0d got=%b exp=%b", k, rd_en, (k <= 4));
            end
            if (k <= 4) begin
                total++;
                if (rd_addr !== 4'(k - 1)) begin
                    bad++;
                    $display("FAIL first_addr n=%0d got=%0d exp=%0d", k, rd_addr, k - 1);
                end
            end
            total++;
            if (de !== (k >= 3)) begin
                bad++;
                $display("FAIL first_de n=%0d got=%b exp=%b", k, de, (k >= 3));
            end
            if (k == 3) begin
                total++;
                if (pixel !== 8'h10 || frame_start !== 1'b1) begin
                    bad++;
                    $display("FAIL first_pixel got=%h/%b exp=10/1", pixel, frame_start);
                end
            end
        end
    endtask

    task automatic test_steady_frame();
        logic [7:0] pix_q[$];
        int         fs_cnt = 0;
        int         p;
        logic [7:0] exp_pix;
        while (n < 90) begin
            tick();
            p       = n - 3;
            exp_pix = is_active(p) ? 8'h10 + 8'(pix_idx(p)) : 8'h00;
            total++;
            if (de !== is_active(p)) begin
                bad++;
                $display("FAIL steady_de n=%0d got=%b exp=%b", n, de, is_active(p));
            end
            total++;
            if (pixel !== exp_pix) begin
                bad++;
                $display("FAIL steady_pixel n=%0d got=%h exp=%h", n, pixel, exp_pix);
            end
            total++;
            if (de !== rd_hist[n-2]) begin
                bad++;
                $display("FAIL read_latency n=%0d got=%b exp=%b", n, de, rd_hist[n-2]);
            end
            total++;
            if (hsync !== (hpos(p) != 5)) begin
                bad++;
                $display("FAIL hsync n=%0d got=%b exp=%b", n, hsync, (hpos(p) != 5));
            end
            total++;
            if (vsync !== (vpos(p) != 4)) begin
                bad++;
                $display("FAIL vsync n=%0d got=%b exp=%b", n, vsync, (vpos(p) != 4));
            end
            total++;
            if (frame_start !== (p % FRAME == 0)) begin
                bad++;
                $display("FAIL frame_start n=%0d got=%b exp=%b", n, frame_start,
                         (p % FRAME == 0));
            end
            if (p >= FRAME && p < 2 * FRAME) begin
                if (de === 1'b1) pix_q.push_back(pixel);
                if (frame_start === 1'b1) fs_cnt++;
            end
        end
        total++;
        if (pix_q.size() != 12) begin
            bad++;
            $display("FAIL frame_pixel_count got=%0d exp=12", pix_q.size());
        end
        for (int i = 0; i < pix_q.size(); i++) begin
            total++;
            if (pix_q[i] !== 8'h10 + 8'(i)) begin
                bad++;
                $display("FAIL raster_order i=%0d got=%h exp=%h", i, pix_q[i], 8'h10 + 8'(i));
            end
        end
        total++;
        if (fs_cnt != 1) begin
            bad++;
            $display("FAIL frame_start_count got=%0d exp=1", fs_cnt);
        end
    endtask

    task automatic test_swap_window();
        int   cnt = 0;
        logic exp_al;
        while (n < 130) begin
            tick();
            exp_al = (vpos(n - 1) == 3) || (vpos(n - 1) == 4);
            total++;
            if (allowed !== exp_al) begin
                bad++;
                $display("FAIL swap_allowed n=%0d got=%b exp=%b", n, allowed, exp_al);
            end
            if (allowed === 1'b1) cnt++;
        end
        total++;
        if (cnt != 14) begin
            bad++;
            $display("FAIL swap_window_len got=%0d exp=14", cnt);
        end
    endtask

    task automatic test_toggle_target();
        int         p;
        int         cnt0 = 0;
        logic [7:0] exp_pix;
        while (n < 135) tick();
        target = 1'b1;  // frame 3 is mid-active here
        while (n < 213) begin
            tick();
            total++;
            if (rd_buf_sel !== (n < 168)) begin
                bad++;
                $display("FAIL buf_sel_hold n=%0d got=%b exp=%b", n, rd_buf_sel, (n < 168));
            end
            p = n - 3;
            if (is_active(p)) begin
                exp_pix = ((p / FRAME) <= 3 ? 8'h10 : 8'h00) + 8'(pix_idx(p));
                total++;
                if (pixel !== exp_pix) begin
                    bad++;
                    $display("FAIL swap_pixel n=%0d got=%h exp=%h", n, pixel, exp_pix);
                end
                if (p / FRAME == 4 && pixel === exp_pix) cnt0++;
            end
        end
        total++;
        if (cnt0 != 12) begin
            bad++;
            $display("FAIL new_buffer_pixels got=%0d exp=12", cnt0);
        end
    endtask

    task automatic test_mid_reset();
        while (n % FRAME != 9) tick();  // counters now at v=1, h=2
        srst = 1'b1;
        @(negedge clk);
        total++;
        if ({rd_en, rd_addr, rd_buf_sel, allowed, de, pixel, frame_start, hsync, vsync}
            !== RST_VEC) begin
            bad++;
            $display("FAIL mid_reset got=%b exp=%b",
                     {rd_en, rd_addr, rd_buf_sel, allowed, de, pixel, frame_start, hsync, vsync},
                     RST_VEC);
        end
        srst = 1'b0;
        n    = 0;
        tick();
        total++;
        if (rd_en !== 1'b1 || rd_addr !== 4'h0) begin
            bad++;
            $display("FAIL restart_read got=%b/%0d exp=1/0", rd_en, rd_addr);
        end
        tick();
        total++;
        if (de !== 1'b0) begin
            bad++;
            $display("FAIL restart_flushed got=%b exp=0", de);
        end
        tick();
        total++;
        if (de !== 1'b1 || pixel !== 8'h10 || frame_start !== 1'b1) begin
            bad++;
            $display("FAIL restart_pixel got=%b/%h/%b exp=1/10/1", de, pixel, frame_start);
        end
    endtask

    // Stub rasterizer finishes every 37 cycles; stub controller swaps only inside the window.
    task automatic test_closed_loop();
        logic pending = 1'b0;
        logic prev_sel;
        int   toggles = 0;
        prev_sel = rd_buf_sel;
        for (int k = 0; k < 260; k++) begin
            tick();
            if (n % 37 == 0) pending = 1'b1;
            total++;
            if (rd_buf_sel !== prev_sel && (n % FRAME) != 0) begin
                bad++;
                $display("FAIL sel_mid_frame n=%0d got=%b exp=%b", n, rd_buf_sel, prev_sel);
            end
            if (n % FRAME == 0) begin
                total++;
                if (rd_buf_sel !== ~target) begin
                    bad++;
                    $display("FAIL sel_latch n=%0d got=%b exp=%b", n, rd_buf_sel, ~target);
                end
            end
            prev_sel = rd_buf_sel;
            if (pending && allowed === 1'b1) begin
                target  = ~target;
                pending = 1'b0;
                toggles++;
            end
        end
        total++;
        if (toggles < 3) begin
            bad++;
            $display("FAIL loop_swaps got=%0d exp>=3", toggles);
        end
    endtask

    initial begin
        srst   = 1'b1;
        target = 1'b0;
        test_reset();
        test_steady_frame();
        test_swap_window();
        test_toggle_target();
        test_mid_reset();
        test_closed_loop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
